coax_control: RTL and testbench
===============================

# coax_control

Parametrised SPI command controller between the SPI slave and the coax TX/RX datapaths. It decodes host command bytes and gives access to control, status and interrupt registers. It streams coax words of configurable width into the TX FIFO and out of the RX FIFO. It drives an interrupt line from sticky, maskable event flags. It supersedes the fixed 10-bit controller and adds configurable word width, interrupt support, an explicit TX start command and single-pulse auto-start.

## Interface
Parameters:
- WORD_WIDTH, 10, coax word width; legal range 9..14.
- DEFAULT_CONTROL_REGISTER, 8'b01001000, control register reset value.
- DEFAULT_IRQ_MASK, 8'h00, IRQ mask reset value.
- AUTO_START, 1, 1 = pulse TX start after chip-select release; 0 = explicit start command only.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- spi_cs  in  1  1 = deselected; forces IDLE.
- spi_rx_data  in  8  received byte.
- spi_rx_strobe  in  1  one-cycle pulse, byte valid.
- spi_tx_data  out  8  next byte to shift out.
- spi_tx_strobe  out  1  one-cycle pulse, load spi_tx_data.
- loopback, tx_parity, rx_parity  out  1  control register bits 0, 3 and 6.
- tx_reset  out  1  one-cycle TX reset pulse.
- tx_active, tx_empty, tx_full, tx_ready  in  1  TX status.
- tx_data  out  WORD_WIDTH  word to enqueue.
- tx_load_strobe  out  1  enqueue tx_data.
- tx_start_strobe  out  1  start transmission.
- rx_reset  out  1  one-cycle RX reset pulse.
- rx_active, rx_error, rx_empty  in  1  RX status.
- rx_data  in  WORD_WIDTH  head of RX FIFO.
- rx_read_strobe  out  1  dequeue RX FIFO.
- irq  out  1  registered, equals |(irq_status & irq_mask).

## Operation
- All outputs are registered. Under reset:
  - every output is 0; tx_data is 0.
  - control register = DEFAULT_CONTROL_REGISTER; irq_mask = DEFAULT_IRQ_MASK; irq_status = 0.
  - state = IDLE; the auto-start arm flag is cleared.
- States: IDLE, RD1, RD2, WR1, WR2, TX1, TX2, TX3, RX1, RX2, RX3, RX4, START, RESET.
- In IDLE, an spi_rx_strobe latches the command byte. The opcode is cmd[3:0] and the selector is cmd[7:4]:
  - 2 → RD1.
  - 3 → WR1.
  - 4 → TX1.
  - 5 → RX1.
  - 6 → START.
  - F → RESET.
  - Any other opcode stays in IDLE.
- Read register (RD1: send byte, go to RD2; RD2: on strobe go to RD1, so the read repeats every byte):
  - Selector 1, status: {0, rx_error, rx_active, ~rx_empty, irq_status[0], tx_active, tx_full, tx_empty}.
  - Selector 2: control register. Selector 3: irq_mask. Selector 4: irq_status.
  - Selector 5: WORD_WIDTH. Selector F: 8'hA5. Any other selector: 8'h00.
- Write register:
  - WR1 latches the mask byte; WR2 latches the data byte, applies the write and returns to IDLE.
  - Selector 2: control register = (reg & ~mask) | (data & mask).
  - Selector 3: irq_mask, same masked-write rule.
  - Selector 4: irq_status bits set in (data & mask) are cleared (write-1-to-clear).
  - Other selectors: discarded.
- TX:
  - TX1 clears irq_status[0].
  - TX2 handles the first byte of each word:
    - tx_full → reply 8'h81 and set irq_status[3].
    - else !tx_ready → reply 8'h82 and set irq_status[3].
    - else reply 8'h00, latch tx_data[WORD_WIDTH-1:8] = byte[WORD_WIDTH-9:0] and mark the word valid.
  - TX3 handles the second byte: tx_data[7:0] = byte; tx_load_strobe = valid; return to TX2.
- RX:
  - RX1 snapshots {rx_error, rx_empty, zero pad, rx_data} into 16 bits.
  - RX2 sends the upper byte.
  - RX3, on strobe, sends the lower byte, then:
    - snapshot error set → rx_reset pulse;
    - else snapshot not empty → rx_read_strobe pulse.
  - RX4, on strobe, goes to RX1.
- START: tx_start_strobe if !tx_empty && !tx_active; go to IDLE.
- RESET: tx_reset and rx_reset pulse; irq_status[0] is cleared; registers are untouched; go to IDLE.
- irq_status bits are sticky:
  - [0] set on tx_active falling edge.
  - [1] set on rx_empty falling edge.
  - [2] set on rx_error rising edge.
  - [3] set on TX overflow/underflow.
  - [7:4] always read 0.
  - When a set and a clear hit the same bit in the same cycle, set wins.
- spi_cs = 1 overrides every state: next state is IDLE and no load or read strobe issues.
- Auto-start (AUTO_START = 1):
  - A rising edge of spi_cs arms a flag.
  - While armed and spi_cs = 1, the first cycle with !tx_empty && !tx_active gives exactly one tx_start_strobe and disarms.
  - spi_cs falling disarms.

## Timing
- Command or data strobe at cycle n → state change at n+1.
- Reply strobes:
  - TX replies: spi_tx_strobe at n+1.
  - Register reads: spi_tx_strobe at n+2.
  - RX upper byte: spi_tx_strobe at n+3.
- tx_load_strobe at n+1 after the second TX byte's strobe.
- rx_read_strobe / rx_reset at n+1 after the RX3 strobe.
- Edge detectors use one registered copy of tx_active, rx_empty and rx_error; an event seen at cycle n sets the flag at n+1 and irq at n+2.
- Reset mid-transfer: asynchronous return to reset values; any partial word is dropped.

## Test plan
- Send 0xF2, then 0x00 → reply 0xA5 twice; 0x52 (WORD_WIDTH = 10) → reply 0x0A.
- Send 0x23, mask 0x01, data 0xFF → control 0x49, loopback = 1; read back 0x49.
- Send 0x04, then 0x02 0xAB 0x01 0xCD → tx_data 0x2AB then 0x1CD, two tx_load_strobes, replies 0x00. Then raise spi_cs → exactly one tx_start_strobe.
- TX with tx_full = 1 → reply 0x81, no load, irq_status = 0x08. Then mask 0x08 → irq = 1. Then 0x43, 0x08, 0x08 → irq = 0.
- RX with rx_data = 0x155, rx_error = 0 → bytes 0x01, 0x55, one rx_read_strobe. With rx_error = 1 → bytes 0x81, 0x55, rx_reset and no read strobe.
- Assert reset during TX3 → all outputs 0 immediately, state IDLE, control register 0x48.

Source files
------------

// File: rtl/coax_control.sv
// SPI command controller: decodes host command bytes, serves control/status/IRQ registers,
// streams coax words into the TX FIFO and out of the RX FIFO, and drives a maskable IRQ.
module coax_control #(
  parameter int         WORD_WIDTH               = 10,
  parameter logic [7:0] DEFAULT_CONTROL_REGISTER = 8'b01001000,
  parameter logic [7:0] DEFAULT_IRQ_MASK         = 8'h00,
  parameter bit         AUTO_START               = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs,
  input  logic [7:0]            spi_rx_data,
  input  logic                  spi_rx_strobe,
  output logic [7:0]            spi_tx_data,
  output logic                  spi_tx_strobe,
  output logic                  loopback,
  output logic                  tx_parity,
  output logic                  rx_parity,
  output logic                  tx_reset,
  input  logic                  tx_active,
  input  logic                  tx_empty,
  input  logic                  tx_full,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_load_strobe,
  output logic                  tx_start_strobe,
  output logic                  rx_reset,
  input  logic                  rx_active,
  input  logic                  rx_error,
  input  logic                  rx_empty,
  input  logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_read_strobe,
  output logic                  irq
);

  typedef enum logic [3:0] {
    IDLE, RD1, RD2, WR1, WR2, TX1, TX2, TX3, RX1, RX2, RX3, RX4, START, RESET
  } state_t;

  state_t      state_q;
  logic [3:0]  sel_q;
  logic [7:0]  wr_mask_q;
  logic [7:0]  ctrl_q;
  logic [7:0]  irq_mask_q;
  logic [7:0]  irq_status_q;
  logic [7:0]  irq_status_d;
  logic [7:0]  irq_set;
  logic [7:0]  irq_clr;
  logic [7:0]  rd_val;
  logic [15:0] rx_snap_q;
  logic        tx_valid_q;
  logic        tx_active_q;
  logic        rx_empty_q;
  logic        rx_error_q;
  logic        cs_q;
  logic        armed_q;
  logic        armed_d;
  logic        auto_fire;

  always_comb begin
    case (sel_q)
      4'h1:    rd_val = {1'b0, rx_error, rx_active, ~rx_empty, irq_status_q[0],
                         tx_active, tx_full, tx_empty};
      4'h2:    rd_val = ctrl_q;
      4'h3:    rd_val = irq_mask_q;
      4'h4:    rd_val = irq_status_q;
      4'h5:    rd_val = 8'(WORD_WIDTH);
      4'hF:    rd_val = 8'hA5;
      default: rd_val = 8'h00;
    endcase
  end

  // Sticky flags: edge events and FSM events set, FSM clears; a set beats a clear.
  always_comb begin
    irq_set    = 8'h00;
    irq_clr    = 8'h00;
    irq_set[0] = tx_active_q & ~tx_active;
    irq_set[1] = rx_empty_q & ~rx_empty;
    irq_set[2] = ~rx_error_q & rx_error;
    if (!spi_cs) begin
      case (state_q)
        TX1:     irq_clr[0] = 1'b1;
        RESET:   irq_clr[0] = 1'b1;
        TX2:     if (spi_rx_strobe && (tx_full || !tx_ready)) irq_set[3] = 1'b1;
        WR2:     if (spi_rx_strobe && sel_q == 4'h4) irq_clr = wr_mask_q & spi_rx_data;
        default: ;
      endcase
    end
    irq_status_d = ((irq_status_q & ~irq_clr) | irq_set) & 8'h0F;
  end

  assign auto_fire = AUTO_START && armed_q && spi_cs && !tx_empty && !tx_active;

  always_comb begin
    armed_d = armed_q;
    if (!AUTO_START)          armed_d = 1'b0;
    else if (!spi_cs && cs_q) armed_d = 1'b0;
    else if (spi_cs && !cs_q) armed_d = 1'b1;
    else if (auto_fire)       armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_active_q  <= 1'b0;
      rx_empty_q   <= 1'b0;
      rx_error_q   <= 1'b0;
      cs_q         <= 1'b1;
      armed_q      <= 1'b0;
      irq_status_q <= 8'h00;
      irq          <= 1'b0;
      loopback     <= 1'b0;
      tx_parity    <= 1'b0;
      rx_parity    <= 1'b0;
    end else begin
      tx_active_q  <= tx_active;
      rx_empty_q   <= rx_empty;
      rx_error_q   <= rx_error;
      cs_q         <= spi_cs;
      armed_q      <= armed_d;
      irq_status_q <= irq_status_d;
      irq          <= |(irq_status_q & irq_mask_q);
      loopback     <= ctrl_q[0];
      tx_parity    <= ctrl_q[3];
      rx_parity    <= ctrl_q[6];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      sel_q           <= 4'h0;
      wr_mask_q       <= 8'h00;
      ctrl_q          <= DEFAULT_CONTROL_REGISTER;
      irq_mask_q      <= DEFAULT_IRQ_MASK;
      rx_snap_q       <= 16'h0000;
      tx_valid_q      <= 1'b0;
      spi_tx_data     <= 8'h00;
      spi_tx_strobe   <= 1'b0;
      tx_data         <= '0;
      tx_load_strobe  <= 1'b0;
      tx_start_strobe <= 1'b0;
      tx_reset        <= 1'b0;
      rx_reset        <= 1'b0;
      rx_read_strobe  <= 1'b0;
    end else begin
      spi_tx_strobe   <= 1'b0;
      tx_load_strobe  <= 1'b0;
      tx_start_strobe <= auto_fire;
      tx_reset        <= 1'b0;
      rx_reset        <= 1'b0;
      rx_read_strobe  <= 1'b0;
      if (spi_cs) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (spi_rx_strobe) begin
            sel_q <= spi_rx_data[7:4];
            case (spi_rx_data[3:0])
              4'h2:    state_q <= RD1;
              4'h3:    state_q <= WR1;
              4'h4:    state_q <= TX1;
              4'h5:    state_q <= RX1;
              4'h6:    state_q <= START;
              4'hF:    state_q <= RESET;
              default: state_q <= IDLE;
            endcase
          end
          RD1: begin
            spi_tx_data   <= rd_val;
            spi_tx_strobe <= 1'b1;
            state_q       <= RD2;
          end
          RD2: if (spi_rx_strobe) state_q <= RD1;
          WR1: if (spi_rx_strobe) begin
            wr_mask_q <= spi_rx_data;
            state_q   <= WR2;
          end
          WR2: if (spi_rx_strobe) begin
            if (sel_q == 4'h2) ctrl_q <= (ctrl_q & ~wr_mask_q) | (spi_rx_data & wr_mask_q);
            if (sel_q == 4'h3) irq_mask_q <= (irq_mask_q & ~wr_mask_q) | (spi_rx_data & wr_mask_q);
            state_q <= IDLE;
          end
          TX1: state_q <= TX2;
          TX2: if (spi_rx_strobe) begin
            spi_tx_strobe <= 1'b1;
            if (tx_full) begin
              spi_tx_data <= 8'h81;
              tx_valid_q  <= 1'b0;
            end else if (!tx_ready) begin
              spi_tx_data <= 8'h82;
              tx_valid_q  <= 1'b0;
            end else begin
              spi_tx_data             <= 8'h00;
              tx_data[WORD_WIDTH-1:8] <= spi_rx_data[WORD_WIDTH-9:0];
              tx_valid_q              <= 1'b1;
            end
            state_q <= TX3;
          end
          TX3: if (spi_rx_strobe) begin
            tx_data[7:0]   <= spi_rx_data;
            tx_load_strobe <= tx_valid_q;
            state_q        <= TX2;
          end
          RX1: begin
            rx_snap_q <= 16'(rx_data) | {rx_error, rx_empty, 14'h0000};
            state_q   <= RX2;
          end
          RX2: begin
            spi_tx_data   <= rx_snap_q[15:8];
            spi_tx_strobe <= 1'b1;
            state_q       <= RX3;
          end
          RX3: if (spi_rx_strobe) begin
            spi_tx_data   <= rx_snap_q[7:0];
            spi_tx_strobe <= 1'b1;
            if (rx_snap_q[15])      rx_reset       <= 1'b1;
            else if (!rx_snap_q[14]) rx_read_strobe <= 1'b1;
            state_q <= RX4;
          end
          RX4: if (spi_rx_strobe) state_q <= RX1;
          START: begin
            if (!tx_empty && !tx_active) tx_start_strobe <= 1'b1;
            state_q <= IDLE;
          end
          RESET: begin
            tx_reset <= 1'b1;
            rx_reset <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coax_control.sv
// Randomized scoreboard bench for coax_control against a transaction-level register/FIFO model.
module tb_coax_control;
  localparam int W = 10;

  logic clk, reset, spi_cs, spi_rx_strobe, spi_tx_strobe;
  logic [7:0] spi_rx_data, spi_tx_data;
  logic loopback, tx_parity, rx_parity, tx_reset, tx_load_strobe, tx_start_strobe;
  logic tx_active, tx_empty, tx_full, tx_ready;
  logic [W-1:0] tx_data, rx_data;
  logic rx_reset, rx_active, rx_error, rx_empty, rx_read_strobe, irq;

  coax_control #(.WORD_WIDTH(W), .DEFAULT_CONTROL_REGISTER(8'h48),
                 .DEFAULT_IRQ_MASK(8'h00), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
    .spi_rx_strobe(spi_rx_strobe), .spi_tx_data(spi_tx_data), .spi_tx_strobe(spi_tx_strobe),
    .loopback(loopback), .tx_parity(tx_parity), .rx_parity(rx_parity), .tx_reset(tx_reset),
    .tx_active(tx_active), .tx_empty(tx_empty), .tx_full(tx_full), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_load_strobe(tx_load_strobe), .tx_start_strobe(tx_start_strobe),
    .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error), .rx_empty(rx_empty),
    .rx_data(rx_data), .rx_read_strobe(rx_read_strobe), .irq(irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]   m_ctrl, m_mask, m_st;
  bit           m_armed;
  bit           s_err, s_emp;
  logic [W-1:0] s_data;

  logic [7:0]   q_reply[$];
  logic [W-1:0] q_load[$];
  int           q_start[$];
  int           q_rxev[$];
  int           q_txrst[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got unexpected pulse (value 0x%0h), expected none at %0t", name, act, $time);
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, spi_tx_data, spi_tx_strobe, loopback, tx_parity, rx_parity, tx_reset,
            tx_data, tx_load_strobe, tx_start_strobe, rx_reset, rx_read_strobe, irq};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (spi_tx_strobe) begin
        if (q_reply.size() == 0) unexpected("spi_reply", spi_tx_data);
        else check("spi_reply", spi_tx_data, q_reply.pop_front());
      end
      if (tx_load_strobe) begin
        if (q_load.size() == 0) unexpected("tx_load", tx_data);
        else check("tx_load", tx_data, q_load.pop_front());
      end
      if (tx_start_strobe) begin
        if (q_start.size() == 0) unexpected("tx_start", 1);
        else begin void'(q_start.pop_front()); n_cmp++; end
      end
      if (tx_reset) begin
        if (q_txrst.size() == 0) unexpected("tx_reset", 1);
        else begin void'(q_txrst.pop_front()); n_cmp++; end
      end
      if (rx_read_strobe) begin
        if (q_rxev.size() == 0) unexpected("rx_read", 1);
        else check("rx_event", 1, q_rxev.pop_front());
      end
      if (rx_reset) begin
        if (q_rxev.size() == 0) unexpected("rx_reset", 2);
        else check("rx_event", 2, q_rxev.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    spi_rx_data   = b;
    spi_rx_strobe = 1'b1;
    tick();
    spi_rx_strobe = 1'b0;
    tick(5);
  endtask

  task automatic cs_low();
    tick();
    spi_cs  = 1'b0;
    m_armed = 0;
    tick(2);
  endtask

  // Releasing chip select arms auto-start; it fires as soon as TX has data and is idle.
  task automatic cs_high();
    tick();
    spi_cs  = 1'b1;
    m_armed = 1;
    if (!tx_empty && !tx_active) begin q_start.push_back(1); m_armed = 0; end
    tick(4);
  endtask

  task automatic set_tx(input bit e, input bit a);
    if (tx_active && !a) m_st |= 8'h01;
    tx_empty  = e;
    tx_active = a;
    if (spi_cs && m_armed && !e && !a) begin q_start.push_back(1); m_armed = 0; end
    tick(2);
  endtask

  task automatic set_rx(input bit err, input bit emp, input logic [W-1:0] d);
    if (rx_empty && !emp)  m_st |= 8'h02;
    if (!rx_error && err)  m_st |= 8'h04;
    rx_error = err; rx_empty = emp; rx_data = d;
    s_err = err; s_emp = emp; s_data = d;
  endtask

  function automatic logic [7:0] rd_expect(input logic [3:0] sel);
    case (sel)
      4'h1:    return {1'b0, rx_error, rx_active, ~rx_empty, m_st[0], tx_active, tx_full, tx_empty};
      4'h2:    return m_ctrl;
      4'h3:    return m_mask;
      4'h4:    return m_st;
      4'h5:    return 8'(W);
      4'hF:    return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic do_read(input logic [3:0] sel, input int reps);
    cs_low();
    q_reply.push_back(rd_expect(sel));
    send_byte({sel, 4'h2});
    for (int i = 0; i < reps; i++) begin
      q_reply.push_back(rd_expect(sel));
      send_byte(8'($urandom));
    end
    cs_high();
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [7:0] mask, input logic [7:0] data);
    cs_low();
    send_byte({sel, 4'h3});
    send_byte(mask);
    send_byte(data);
    if (sel == 4'h2) m_ctrl = (m_ctrl & ~mask) | (data & mask);
    if (sel == 4'h3) m_mask = (m_mask & ~mask) | (data & mask);
    if (sel == 4'h4) m_st   = m_st & ~(data & mask);
    cs_high();
  endtask

  task automatic tx_begin(input bit e);
    cs_low();
    set_tx(e, tx_active);
    send_byte({4'($urandom), 4'h4});
    m_st &= 8'hFE;
  endtask

  task automatic tx_word(input logic [7:0] b1, input logic [7:0] b2, input bit full, input bit ready);
    bit ok;
    tx_full  = full;
    tx_ready = ready;
    ok = 0;
    if (full)        begin q_reply.push_back(8'h81); m_st |= 8'h08; end
    else if (!ready) begin q_reply.push_back(8'h82); m_st |= 8'h08; end
    else             begin q_reply.push_back(8'h00); ok = 1; end
    send_byte(b1);
    if (ok) q_load.push_back(W'((int'(b1) % (1 << (W - 8))) * 256 + int'(b2)));
    send_byte(b2);
  endtask

  function automatic logic [7:0] rx_upper();
    return 8'((int'(s_err) << 7) + (int'(s_emp) << 6) + (int'(s_data) >> 8));
  endfunction

  task automatic rx_begin(input bit err, input bit emp, input logic [W-1:0] d);
    cs_low();
    set_rx(err, emp, d);
    q_reply.push_back(rx_upper());
    send_byte({4'($urandom), 4'h5});
  endtask

  task automatic rx_lower();
    q_reply.push_back(s_data[7:0]);
    if (s_err)       q_rxev.push_back(2);
    else if (!s_emp) q_rxev.push_back(1);
    send_byte(8'($urandom));
  endtask

  task automatic rx_next(input bit err, input bit emp, input logic [W-1:0] d);
    set_rx(err, emp, d);
    q_reply.push_back(rx_upper());
    send_byte(8'($urandom));
  endtask

  task automatic do_start();
    bit e, a;
    e = 1'($urandom);
    a = 1'($urandom);
    cs_low();
    set_tx(e, a);
    if (!e && !a) q_start.push_back(1);
    send_byte({4'($urandom), 4'h6});
    cs_high();
  endtask

  task automatic do_reset_cmd();
    cs_low();
    q_rxev.push_back(2);
    q_txrst.push_back(1);
    send_byte({4'($urandom), 4'hF});
    m_st &= 8'hFE;
    cs_high();
  endtask

  task automatic do_invalid();
    int op;
    op = $urandom_range(7, 16);
    if (op > 14) op -= 15;
    cs_low();
    send_byte({4'($urandom), 4'(op)});
    cs_high();
  endtask

  task automatic check_misc();
    tick(3);
    check("irq", irq, ((m_st & m_mask) != 0));
    check("ctrl_bits", {rx_parity, tx_parity, loopback}, {m_ctrl[6], m_ctrl[3], m_ctrl[0]});
  endtask

  task automatic model_reset();
    m_ctrl = 8'h48; m_mask = 8'h00; m_st = 8'h00; m_armed = 0;
  endtask

  initial begin
    #2000000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; spi_cs = 1'b1; spi_rx_data = 8'h00; spi_rx_strobe = 1'b0;
    tx_active = 1'b0; tx_empty = 1'b1; tx_full = 1'b0; tx_ready = 1'b1;
    rx_active = 1'b0; rx_error = 1'b0; rx_empty = 1'b1; rx_data = '0;
    s_err = 0; s_emp = 1; s_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_misc();

    do_read(4'hF, 1);
    do_read(4'h5, 0);
    do_write(4'h2, 8'h01, 8'hFF);
    check_misc();
    check("loopback_set", loopback, 1'b1);
    do_read(4'h2, 0);

    tx_begin(1'b0);
    tx_word(8'h02, 8'hAB, 1'b0, 1'b1);
    tx_word(8'h01, 8'hCD, 1'b0, 1'b1);
    cs_high();

    tx_begin(1'b1);
    tx_word(8'h00, 8'h11, 1'b1, 1'b1);
    cs_high();
    check_misc();
    do_read(4'h4, 0);
    do_write(4'h3, 8'h08, 8'h08);
    check_misc();
    check("irq_masked_on", irq, 1'b1);
    do_write(4'h4, 8'h08, 8'h08);
    check_misc();

    cs_low();
    set_tx(1'b0, 1'b1);
    cs_high();
    set_tx(1'b0, 1'b0);
    check_misc();
    do_read(4'h4, 0);
    do_reset_cmd();

    rx_begin(1'b0, 1'b0, W'(10'h155));
    rx_lower();
    cs_high();
    rx_begin(1'b1, 1'b0, W'(10'h155));
    rx_lower();
    cs_high();
    set_rx(1'b0, 1'b1, '0);
    check_misc();
    do_read(4'h4, 0);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: begin
          logic [3:0] sel;
          sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(2, 4));
          do_write(sel, 8'($urandom), 8'($urandom));
        end
        1: begin
          rx_active = 1'($urandom);
          do_read(4'($urandom), $urandom_range(0, 2));
        end
        2: begin
          int n;
          n = $urandom_range(1, 3);
          tx_begin(1'($urandom));
          for (int k = 0; k < n; k++)
            tx_word(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0));
          cs_high();
        end
        3: begin
          int n;
          n = $urandom_range(1, 3);
          rx_begin(($urandom_range(0, 3) == 0), 1'($urandom), W'($urandom));
          for (int k = 0; k < n; k++) begin
            rx_lower();
            if (k < n - 1) rx_next(($urandom_range(0, 3) == 0), 1'($urandom), W'($urandom));
          end
          cs_high();
        end
        4: do_start();
        5: do_reset_cmd();
        default: do_invalid();
      endcase
      check_misc();
    end

    // Asynchronous reset while a TX word is half received.
    cs_low();
    set_tx(1'b1, 1'b0);
    set_rx(1'b0, 1'b1, '0);
    tx_full = 1'b0;
    tx_ready = 1'b1;
    send_byte(8'h04);
    q_reply.push_back(8'h00);
    send_byte(8'h03);
    #2 reset = 1'b1;
    #1 check("reset_async", outs(), 32'h0);
    spi_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check_misc();
    do_read(4'h2, 0);
    tx_begin(1'b1);
    tx_word(8'h03, 8'h44, 1'b0, 1'b1);
    cs_high();
    check_misc();

    tick(10);
    check("reply_queue_left", q_reply.size(), 0);
    check("load_queue_left", q_load.size(), 0);
    check("start_queue_left", q_start.size(), 0);
    check("rx_event_queue_left", q_rxev.size(), 0);
    check("tx_reset_queue_left", q_txrst.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
